// File: rtl/ws2812_input_pkg.sv
// Shared timing constants and state encoding for the WS2812 receiver.
// Defaults assume a 12 MHz clock, matching the ws2812_output transmitter.
package ws2812_input_pkg;

    localparam int DEF_THRESHOLD_CYCLES = 7;    // 0.6 us
    localparam int DEF_MAX_HIGH_CYCLES  = 14;
    localparam int DEF_RESET_CYCLES     = 600;  // 50 us latch gap
    localparam int DEF_OWN_BYTES        = 3;

    typedef enum logic [1:0] {
        WAIT_GAP,
        ARMED,
        HIGH,
        LOW
    } rx_state_t;

endpackage

// File: rtl/ws2812_input_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus rise/fall detection
// on the synchronized value.
module ws2812_input_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic DIN,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= DIN;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign din_s = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/ws2812_input.sv
// WS2812 one-wire receiver: classifies high-pulse widths into bits, assembles MSB-first bytes
// and detects the latch gap. Define WS2812_INPUT_FORWARD_EN to forward bytes past OWN_BYTES on DOUT_FWD.
module ws2812_input
    import ws2812_input_pkg::*;
#(
    parameter int THRESHOLD_CYCLES = DEF_THRESHOLD_CYCLES,
    parameter int MAX_HIGH_CYCLES  = DEF_MAX_HIGH_CYCLES,
    parameter int RESET_CYCLES     = DEF_RESET_CYCLES
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       DIN,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    output logic       FRAME_END,
    output logic       ERROR,
    output logic [7:0] BYTE_COUNT,
    output logic       DOUT_FWD
);

    localparam int               CNT_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESHOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAXHI  = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(RESET_CYCLES);

    logic             din_s;
    logic             rise;
    logic             fall;
    rx_state_t        state_reg;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic [7:0]       byte_count_reg;
    logic             data_valid_reg;
    logic             frame_end_reg;
    logic             error_reg;
    logic             clr_frame;
    logic             shift_en;
    logic             drop_bits;
    logic             err_next;
    logic             fend_next;
    logic             bit_val;

    ws2812_input_sync u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DIN   (DIN),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    // cnt equals the width of the current level in cycles when the next edge arrives
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt_reg <= '0;
        else if (state_reg == WAIT_GAP && din_s)
            cnt_reg <= '0;
        else if (rise || fall)
            cnt_reg <= CNT_W'(1);
        else if (cnt_reg != CNT_RESET)
            cnt_reg <= cnt_reg + CNT_W'(1);
    end

    assign bit_val = (cnt_reg >= CNT_THRESH);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state_reg <= WAIT_GAP;
        else
            state_reg <= state_next;
    end

    // A gap completing in the same cycle as a new rise starts the next frame directly
    always_comb begin
        state_next = state_reg;
        clr_frame  = 1'b0;
        shift_en   = 1'b0;
        drop_bits  = 1'b0;
        err_next   = 1'b0;
        fend_next  = 1'b0;
        case (state_reg)
            WAIT_GAP: begin
                if (cnt_reg == CNT_RESET) begin
                    state_next = rise ? HIGH : ARMED;
                    clr_frame  = rise;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_next = HIGH;
                    clr_frame  = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_reg >= CNT_MAXHI) begin
                    state_next = WAIT_GAP;
                    err_next   = 1'b1;
                    drop_bits  = 1'b1;
                end else if (fall) begin
                    state_next = LOW;
                    shift_en   = 1'b1;
                end
            end
            LOW: begin
                if (cnt_reg == CNT_RESET) begin
                    state_next = rise ? HIGH : ARMED;
                    fend_next  = 1'b1;
                    err_next   = (bit_cnt_reg != 3'd0);
                    drop_bits  = 1'b1;
                    clr_frame  = rise;
                end else if (rise) begin
                    state_next = HIGH;
                end
            end
            default: state_next = WAIT_GAP;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            data_reg       <= '0;
            byte_count_reg <= '0;
            data_valid_reg <= 1'b0;
            frame_end_reg  <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            frame_end_reg  <= fend_next;
            error_reg      <= err_next;
            if (clr_frame) begin
                byte_count_reg <= '0;
                bit_cnt_reg    <= '0;
            end else if (drop_bits) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                shift_reg   <= {shift_reg[6:0], bit_val};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    data_reg       <= {shift_reg[6:0], bit_val};
                    data_valid_reg <= 1'b1;
                    if (byte_count_reg != 8'hFF)
                        byte_count_reg <= byte_count_reg + 8'd1;
                end
            end
        end
    end

    assign DATA       = data_reg;
    assign DATA_VALID = data_valid_reg;
    assign FRAME_END  = frame_end_reg;
    assign ERROR      = error_reg;
    assign BYTE_COUNT = byte_count_reg;

`ifdef WS2812_INPUT_FORWARD_EN
    logic gate_reg;
    logic gate_open;
    logic gate_latch;

    // Decision is taken at a rise and applied combinationally so the first pulse is not clipped
    assign gate_latch = rise && (state_reg == ARMED || state_reg == LOW);
    assign gate_open  = (state_reg == ARMED) ? (DEF_OWN_BYTES == 0)
                      : (byte_count_reg >= 8'(DEF_OWN_BYTES) && bit_cnt_reg == 3'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            gate_reg <= 1'b0;
        else if (fend_next || err_next)
            gate_reg <= 1'b0;
        else if (gate_latch && gate_open)
            gate_reg <= 1'b1;
    end

    assign DOUT_FWD = din_s & ~fend_next & ~err_next & (gate_reg | (gate_latch & gate_open));
`else
    assign DOUT_FWD = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_input.sv
// Directed bench for ws2812_input: decoding, latch gap, protocol errors, async reset and forwarding.
module tb_ws2812_input;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       DIN   = 1'b0;
    logic [7:0] DATA;
    logic       DATA_VALID;
    logic       FRAME_END;
    logic       ERROR;
    logic [7:0] BYTE_COUNT;
    logic       DOUT_FWD;

    int compared   = 0;
    int mismatched = 0;

    int dv_cnt     = 0;
    int fe_cnt     = 0;
    int err_cnt    = 0;
    int fe_err_cnt = 0;
    int fwd_bad    = 0;
    int fwd_high   = 0;
    logic [7:0] byte_log[$];
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    logic fwd_en = 1'b0;

    ws2812_input dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN        (DIN),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .FRAME_END  (FRAME_END),
        .ERROR      (ERROR),
        .BYTE_COUNT (BYTE_COUNT),
        .DOUT_FWD   (DOUT_FWD)
    );

    always #5 CLK = ~CLK;

    // d2 tracks DIN delayed by two clocks, the expected forwarded line
    always @(posedge CLK) begin
        d2 = d1;
        d1 = DIN;
    end

    always @(negedge CLK) begin
        if (DATA_VALID === 1'b1) begin
            dv_cnt++;
            byte_log.push_back(DATA);
            $display("rx byte %0d: data=%02h byte_count=%0d", dv_cnt, DATA, BYTE_COUNT);
        end
        if (FRAME_END === 1'b1) begin
            fe_cnt++;
            $display("frame end %0d (error=%0b)", fe_cnt, ERROR);
        end
        if (ERROR === 1'b1) begin
            err_cnt++;
            $display("protocol error %0d", err_cnt);
        end
        if (FRAME_END === 1'b1 && ERROR === 1'b1)
            fe_err_cnt++;
        if (DOUT_FWD !== (d2 & fwd_en))
            fwd_bad++;
        if (DOUT_FWD === 1'b1)
            fwd_high++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        DIN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 10);
            drive(1'b0, 5);
        end else begin
            drive(1'b1, 5);
            drive(1'b0, 10);
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--)
            send_bit(v[i]);
    endtask

    initial begin
        RST_N = 1'b0;
        DIN   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_data", DATA, 8'h00);
        check("rst_dv", DATA_VALID, 1'b0);
        check("rst_fe", FRAME_END, 1'b0);
        check("rst_err", ERROR, 1'b0);
        check("rst_bc", BYTE_COUNT, 8'h00);
        check("rst_fwd", DOUT_FWD, 1'b0);
        RST_N = 1'b1;

        // Initial gap, then 0xA5 with the last bit timed by hand for the latency check
        drive(1'b0, 620);
        send_bits(8'hA5, 7);
        drive(1'b1, 10);
        DIN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("lat_dv_early", DATA_VALID, 1'b0);
        @(negedge CLK);
        check("lat_dv", DATA_VALID, 1'b1);
        check("a5_data", DATA, 8'hA5);
        check("a5_bc", BYTE_COUNT, 8'd1);
        drive(1'b0, 2);
        check("a5_dv_cnt", dv_cnt, 1);

        drive(1'b0, 620);
        check("gap1_fe", fe_cnt, 1);
        check("gap1_err", err_cnt, 0);

        send_bits(8'hFF, 8);
        send_bits(8'h00, 8);
        send_bits(8'h3C, 8);
        drive(1'b0, 10);
        check("three_dv_cnt", dv_cnt, 4);
        check("three_b0", byte_log[1], 8'hFF);
        check("three_b1", byte_log[2], 8'h00);
        check("three_b2", byte_log[3], 8'h3C);
        check("three_bc", BYTE_COUNT, 8'd3);
        drive(1'b0, 620);
        check("gap2_fe", fe_cnt, 2);
        check("gap2_err", err_cnt, 0);

        // Over-long high pulse, then traffic that must be ignored until a gap
        drive(1'b1, 16);
        drive(1'b0, 10);
        check("long_err", err_cnt, 1);
        send_bits(8'h55, 8);
        drive(1'b0, 10);
        check("ignored_dv", dv_cnt, 4);
        check("data_hold", DATA, 8'h3C);
        drive(1'b0, 620);
        check("wait_gap_no_fe", fe_cnt, 2);

        // Partial byte terminated by a gap
        send_bits(8'hB0, 5);
        drive(1'b0, 620);
        check("partial_fe", fe_cnt, 3);
        check("partial_err", err_cnt, 2);
        check("partial_same_cycle", fe_err_cnt, 1);
        check("partial_no_dv", dv_cnt, 4);

        // Six-byte frame; only bytes 3..5 may appear on the forwarded line
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
`ifdef WS2812_INPUT_FORWARD_EN
        fwd_en = 1'b1;
`endif
        send_bits(8'hF0, 8);
        send_bits(8'h0F, 8);
        send_bits(8'hAA, 8);
        drive(1'b0, 10);
        check("six_dv_cnt", dv_cnt, 10);
        check("six_bc", BYTE_COUNT, 8'd6);
        check("six_last", DATA, 8'hAA);
        drive(1'b0, 620);
        fwd_en = 1'b0;
        check("six_fe", fe_cnt, 4);

        // Asynchronous reset in the middle of a byte
        send_bits(8'h81, 8);
        send_bits(8'hE0, 3);
        check("pre_rst_data", DATA, 8'h81);
        check("pre_rst_bc", BYTE_COUNT, 8'd1);
        drive(1'b1, 3);
        RST_N = 1'b0;
        #1;
        check("async_rst_data", DATA, 8'h00);
        check("async_rst_bc", BYTE_COUNT, 8'h00);
        check("async_rst_dv", DATA_VALID, 1'b0);
        check("async_rst_fwd", DOUT_FWD, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 10);
        send_bits(8'h99, 8);
        drive(1'b0, 10);
        check("tail_ignored", dv_cnt, 11);

        drive(1'b0, 620);
        send_bits(8'h42, 8);
        drive(1'b0, 10);
        check("post_rst_data", DATA, 8'h42);
        check("post_rst_dv", dv_cnt, 12);
        drive(1'b0, 620);
        check("final_fe", fe_cnt, 5);
        check("final_err", err_cnt, 2);
        check("fwd_match", fwd_bad, 0);
`ifdef WS2812_INPUT_FORWARD_EN
        check("fwd_high_cycles", fwd_high, 180);
`else
        check("fwd_high_cycles", fwd_high, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
